load_store_unit: RTL and testbench

- Sits between the core's execute/memory stage and the word-addressed data memory.
- Accepts one load or store request at a time and supports byte, halfword and word sizes.
- Drives the memory's word address, write data and write enable, and consumes its combinational read data.
- Sub-word stores use a read-modify-write sequence, because the memory writes whole words only. Loads are sign- or zero-extended. Misaligned and out-of-range accesses are rejected with an error response.

---
 rtl/load_store_unit.sv | 132 +++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between the execute/memory stage and a word-addressed data memory.
// Sub-word stores use read-modify-write; loads are sign- or zero-extended.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      state_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic        err_q;
  logic [31:0] data_q;

  logic        req_err;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [31:0] shifted;
  logic [15:0] half_sel;

  always_comb begin
    req_err = 1'b0;
    if (req_size == SZ_ILL) req_err = 1'b1;
    if (req_size == SZ_HALF && req_addr[0]) req_err = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if ({2'b00, req_addr[31:2]} >= MEM_WORDS) req_err = 1'b1;
  end

  always_comb begin
    shifted  = mem_read_data >> {addr_q[1:0], 3'b000};
    half_sel = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    load_ext = mem_read_data;
    merged   = mem_read_data;
    case (size_q)
      SZ_BYTE: begin
        load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      SZ_HALF: begin
        load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata[15:0];
            err_q   <= req_err;
            // word stores skip the read; the full store word becomes the write data directly
            data_q  <= (req_we && req_size == SZ_WORD) ? req_wdata : '0;
            if (req_err)
              state_q <= S_DONE;
            else if (req_we && req_size == SZ_WORD)
              state_q <= S_WRITE;
            else
              state_q <= S_READ;
          end
        end
        S_READ: begin
          if (we_q) begin
            data_q  <= merged;
            state_q <= S_WRITE;
          end else begin
            data_q  <= load_ext;
            state_q <= S_DONE;
          end
        end
        S_WRITE: state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready        = (state_q == S_IDLE);
    resp_valid       = (state_q == S_DONE);
    resp_err         = (state_q == S_DONE) && err_q;
    resp_rdata       = (state_q == S_DONE && !we_q && !err_q) ? data_q : '0;
    mem_address      = (state_q == S_READ || state_q == S_WRITE) ? {addr_q[31:2], 2'b00} : '0;
    mem_write_data   = (state_q == S_WRITE) ? data_q : '0;
    mem_write_enable = (state_q == S_WRITE) && !rst;
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(255)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_err         (resp_err),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  always_comb mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write_enable && mem_address < 32'd1024)
      mem[mem_address[9:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: expected response and memory effect from the access rules, then drive and observe.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata, old, part, mask, nw, exp_waddr;
    int unsigned exp_lat, exp_writes, sh, wi;
    int unsigned lat, writes;
    logic [31:0] waddr, wd, rdata;
    logic        err, done;

    exp_err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= 32'd255);
    wi  = exp_err ? 0 : int'(addr / 4);
    sh  = int'(addr % 4) * 8;
    old = ref_mem[wi];
    exp_rdata = 32'h0; exp_writes = 0; exp_waddr = 32'h0; nw = 32'h0;
    if (exp_err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      if (size == 2'd0) begin
        part = (old >> sh) & 32'hFF;
        exp_rdata = (!uns && part >= 32'd128) ? (part | 32'hFFFF_FF00) : part;
      end else if (size == 2'd1) begin
        part = (old >> sh) & 32'hFFFF;
        exp_rdata = (!uns && part >= 32'd32768) ? (part | 32'hFFFF_0000) : part;
      end else begin
        exp_rdata = old;
      end
    end else begin
      exp_writes = 1;
      exp_waddr  = 32'(wi * 4);
      if (size == 2'd2) begin
        exp_lat = 2;
        nw = wdata;
      end else begin
        exp_lat = 3;
        mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        nw = (old & ~mask) | ((wdata << sh) & mask);
      end
      ref_mem[wi] = nw;
    end

    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check("ready_idle", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    lat = 0; writes = 0; waddr = 32'h0; wd = 32'h0; rdata = 32'h0; err = 1'b0; done = 1'b0;
    for (int k = 1; k <= 8 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("ready_busy", {31'h0, req_ready}, 32'h0);
        req_valid = 1'b0;
      end
      if (mem_write_enable) begin
        writes++;
        waddr = mem_address;
        wd    = mem_write_data;
      end
      if (resp_valid) begin
        done  = 1'b1;
        lat   = k;
        rdata = resp_rdata;
        err   = resp_err;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", {31'h0, err}, {31'h0, exp_err});
    check("resp_rdata", rdata, exp_rdata);
    check("write_count", 32'(writes), 32'(exp_writes));
    if (exp_writes != 0) begin
      check("write_addr", waddr, exp_waddr);
      check("write_data", wd, nw);
    end
    if (!exp_err) check("mem_word", mem[wi[7:0]], ref_mem[wi]);
  endtask

  initial begin
    int unsigned cyc1, cyc2, writes_seen, resps_seen;
    logic [31:0] d1, d2;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h1234_5678; ref_mem[1] = 32'h1234_5678;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_we", {31'h0, mem_write_enable}, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    rst = 1'b0;

    // directed loads
    run_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    run_req(1'b0, 2'd0, 1'b0, 32'h3, 32'h0);
    run_req(1'b0, 2'd0, 1'b1, 32'h3, 32'h0);
    run_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
    run_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
    // sub-word store then read back
    run_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h55);
    run_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    check("word1_after_sb", ref_mem[1], 32'h1234_5578);
    // errors
    run_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0);
    run_req(1'b1, 2'd1, 1'b0, 32'h1, 32'hFFFF);
    run_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
    run_req(1'b0, 2'd2, 1'b0, 32'h3F8, 32'h0);
    run_req(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);

    // reset during READ of a sub-word store
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'hAA;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstread_we", {31'h0, mem_write_enable}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstread_ready", {31'h0, req_ready}, 32'h1);
    writes_seen = 0; resps_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (mem_write_enable) writes_seen++;
      if (resp_valid) resps_seen++;
      @(negedge clk);
    end
    check("rstread_writes", 32'(writes_seen), 32'h0);
    check("rstread_resps", 32'(resps_seen), 32'h0);
    check("rstread_word0", mem[0], 32'hDEAD_BEEF);

    // reset asserted while in WRITE must suppress the strobe
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h8; req_wdata = 32'h11; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rstwrite_pre", {31'h0, mem_write_enable}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstwrite_gated", {31'h0, mem_write_enable}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstwrite_word2", mem[2], ref_mem[2]);

    // halfword store to upper lane
    run_req(1'b1, 2'd1, 1'b0, 32'h2, 32'h0000_CAFE);
    check("word0_after_sh", ref_mem[0], 32'hCAFE_BEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);

    // back-to-back loads with req_valid held high
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    cyc1 = 0; cyc2 = 0; d1 = 32'h0; d2 = 32'h0;
    for (int k = 1; k <= 10 && cyc2 == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("b2b_busy", {31'h0, req_ready}, 32'h0);
        req_addr = 32'h4;
      end
      if (resp_valid) begin
        if (cyc1 == 0) begin
          cyc1 = k; d1 = resp_rdata;
        end else begin
          cyc2 = k; d2 = resp_rdata;
        end
      end
      if (k == 3) check("b2b_ready_after_done", {31'h0, req_ready}, 32'h1);
    end
    req_valid = 1'b0;
    check("b2b_cyc1", 32'(cyc1), 32'd2);
    check("b2b_data1", d1, ref_mem[0]);
    check("b2b_cyc2", 32'(cyc2), 32'd5);
    check("b2b_data2", d2, ref_mem[1]);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      a  = ($urandom % 8 == 0) ? 32'($urandom_range(1000, 1040)) : 32'($urandom % 32);
      run_req(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
